die_button_conditioner: RTL
===========================

Name: die_button_conditioner

Overview:
Parametrised successor to the per-button debounce and die-select encoder chain in the dice roller top level. It takes N_BTN raw die buttons plus one raw test switch and synchronises, debounces and edge-detects each one. It produces a latched die-select code with a one-cycle strobe for the roll logic, and a debounced test-mode level. It sits directly behind the board pins and feeds the roll/display logic.

Parameters:
N_BTN, 6, number of die buttons; index 0 is highest priority.
DB_CYCLES, 50000, clock cycles a synchronised input must differ from its debounced level before that level flips; must be >= 1.
CNT_W, 16, debounce counter width; elaboration error if 2**CNT_W <= DB_CYCLES.
SEL_W, 3, die_select width; elaboration error if 2**SEL_W <= N_BTN.
REPEAT_CYCLES, 1000000, auto-repeat period; used only with the optional feature.

Ports:
clk  input  1  single system clock; all logic on its rising edge
reset  input  1  asynchronous, active-high reset
btn_raw  input  N_BTN  raw, unsynchronised die buttons; 1 = pressed
test_sw_raw  input  1  raw, unsynchronised test switch
btn_level  output  N_BTN  debounced button levels
btn_press  output  N_BTN  one-cycle pulse per debounced rising edge
die_select  output  SEL_W  latched selection code; 0 = none, i+1 = button i
sel_strobe  output  1  one-cycle pulse when die_select is (re)loaded
test_mode  output  1  debounced test switch level

Behaviour:
- Reset: all synchroniser flops, counters, btn_level, btn_press, die_select, sel_strobe and test_mode go to 0 immediately. Reset asserted mid-count discards any partial debounce. There is no output activity until reset deasserts.
- Synchroniser: two flops per input (N_BTN+1 channels), reset to 0.
- Debounce, per channel (the test switch uses an identical channel):
  - If sync != level, the counter increments. If sync == level, the counter clears to 0.
  - When the counter equals DB_CYCLES-1 and sync != level: level <= sync and counter <= 0.
  - A glitch shorter than DB_CYCLES synchronised cycles never changes the level. Any bounce restarts the count.
  - Latency: the raw change is first sampled at edge k; btn_level changes at edge k+1+DB_CYCLES.
- btn_press[i] is high for exactly the cycle in which btn_level[i] rises. There is no pulse on a fall.
- Encoder, one registered stage after btn_press:
  - If any btn_press bit is set and test_mode == 0: die_select <= (lowest set index)+1 and sel_strobe = 1 on the next cycle.
  - Simultaneous presses: the lowest index wins. Other presses are dropped, not queued.
  - A press while test_mode == 1: btn_press still pulses, but die_select holds and sel_strobe stays 0.
  - die_select holds its value indefinitely. It is never cleared by release, only by reset.
- Re-pressing the same button reloads the same code and strobes again.
- test_mode follows the debounced test switch with the same latency as the buttons.

Optional Feature:
Macro DIE_BTN_REPEAT_EN.
- Defined: while the button that last loaded die_select keeps btn_level high and test_mode == 0, a repeat counter runs. sel_strobe re-pulses every REPEAT_CYCLES cycles, measured from the original strobe, with die_select unchanged.
  - The counter clears on release, on a new press of any button, on test_mode rising, and on reset.
- Undefined: no repeat counter exists, and there is exactly one strobe per accepted press.

Test Plan (DB_CYCLES=4, N_BTN=6, REPEAT_CYCLES=10):
- Reset released, btn_raw[2] held high from edge 0 -> btn_level[2] rises at edge 5, btn_press[2] pulses once, die_select=3 and sel_strobe pulse at edge 6.
- btn_raw[0] toggled high 3 cycles / low 1 cycle for 20 cycles, then held -> no level change during bounce; level rises 5 edges after the final rising toggle; die_select=1.
- btn_raw[1] and btn_raw[4] rise on the same edge -> both btn_press bits pulse together, die_select=2, exactly one sel_strobe.
- test_sw_raw high for 10 cycles, then press btn 5 -> test_mode=1, btn_press[5] pulses, die_select holds the prior value, no sel_strobe; lower test_sw_raw and re-press -> die_select=6 with strobe.
- reset asserted 2 cycles into a btn 3 count, then released with btn 3 still held -> all outputs 0 immediately; level rises a full 5 edges after the first post-reset sample edge.
- With DIE_BTN_REPEAT_EN, hold btn 1 for 35 cycles past the first strobe -> strobes at +0, +10, +20, +30 with die_select=2; release -> no further strobes.

Source files
------------

// File: rtl/die_button_conditioner.sv
// Synchronises, debounces and edge-detects N_BTN die buttons plus a test switch,
// then encodes presses into a latched die-select code. Optional auto-repeat: DIE_BTN_REPEAT_EN.
module die_button_conditioner #(
  parameter int N_BTN         = 6,
  parameter int DB_CYCLES     = 50000,
  parameter int CNT_W         = 16,
  parameter int SEL_W         = 3,
  parameter int REPEAT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             test_sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [SEL_W-1:0] die_select,
  output logic             sel_strobe,
  output logic             test_mode
);

  localparam int NCH = N_BTN + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 1) begin : g_bad_db
    $error("DB_CYCLES must be at least 1");
  end
  if ((64'd1 << CNT_W) <= 64'(DB_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DB_CYCLES");
  end
  if ((64'd1 << SEL_W) <= 64'(N_BTN)) begin : g_bad_sel_w
    $error("SEL_W too narrow for N_BTN");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  logic [NCH-1:0]   raw_all;
  logic [NCH-1:0]   sync_a;
  logic [NCH-1:0]   sync_b;
  logic [NCH-1:0]   level_all;
  logic [N_BTN-1:0] rise;

  // The test switch rides along as the top channel so it gets identical treatment.
  assign raw_all = {test_sw_raw, btn_raw};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw_all;
      sync_b <= sync_a;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    // The counter only survives while the synchronised input disagrees with the level.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync_b[c] != lvl) begin
        if (cnt == CNT_LAST) begin
          lvl <= sync_b[c];
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end

    assign level_all[c] = lvl;

    if (c < N_BTN) begin : g_rise
      assign rise[c] = sync_b[c] && !lvl && (cnt == CNT_LAST);
    end
  end

  assign btn_level = level_all[N_BTN-1:0];
  assign test_mode = level_all[N_BTN];

  // Registered alongside the level flop so the pulse coincides with the new high level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_press <= '0;
    end else begin
      btn_press <= rise;
    end
  end

  logic [SEL_W-1:0] first_code;
  logic             accept;
  logic             repeat_fire;

  always_comb begin
    first_code = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn_press[i]) begin
        first_code = SEL_W'(i + 1);
      end
    end
  end

  assign accept = (|btn_press) && !test_mode;

`ifdef DIE_BTN_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             held;
  logic             rpt_clear;

  always_comb begin
    held = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (die_select == SEL_W'(i + 1)) begin
        held = btn_level[i];
      end
    end
  end

  // Any press (accepted or not), release or test mode restarts the repeat period.
  assign rpt_clear   = (|btn_press) || !held || test_mode;
  assign repeat_fire = !rpt_clear && (rpt_cnt == RPT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt <= '0;
    end else if (rpt_clear || repeat_fire) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      die_select <= '0;
      sel_strobe <= 1'b0;
    end else begin
      sel_strobe <= accept || repeat_fire;
      if (accept) begin
        die_select <= first_code;
      end
    end
  end

endmodule
